duck_sprite_fetch: RTL and testbench

Per-pixel sprite fetch stage for the duck layer, placed between the VGA controller and the duck palette lookup. It converts the beam position into a sprite ROM address and sequences the duck animation frames. It reads the 4-bit colour index returned by the ROM and presents it to the palette with a transparency-qualified `pixel_on` flag. All outputs are registered and have a fixed 3-cycle latency relative to `DrawX`/`DrawY`.

---
 rtl/duck_sprite_fetch.sv | 121 ++++++++++++
 tb/tb_duck_sprite_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/duck_sprite_fetch.sv
// Duck layer sprite fetch: beam position -> sprite ROM address -> palette index, 3-cycle latency.
// Optional horizontal flip enabled by defining DUCK_MIRROR_EN.
module duck_sprite_fetch #(
  parameter int unsigned SPRITE_W        = 64,
  parameter int unsigned SPRITE_H        = 64,
  parameter int unsigned FRAMES          = 4,
  parameter int unsigned FRAME_DIV       = 8,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h0,
  parameter int unsigned ADDR_W          = $clog2(FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       vsync,
  input  logic [9:0]                 duck_x,
  input  logic [9:0]                 duck_y,
  input  logic                       duck_en,
  input  logic                       mirror,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [3:0]                 rom_q,
  output logic [3:0]                 pal_index,
  output logic                       pixel_on,
  output logic [$clog2(FRAMES)-1:0]  frame
);

  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned FW = $clog2(FRAMES);
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic          vsync_d;
  logic          frame_start;
  logic [9:0]    x_s, y_s;
  logic          en_s;
  logic [DW-1:0] div_cnt;
  logic          inbox, inbox_d1, inbox_d2;
  logic [10:0]   x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
  logic [CW-1:0] col_raw, col;
  logic [RW-1:0] row;

  assign frame_start = vsync_d & ~vsync;

  // 11-bit compare so a box near the right/bottom edge never wraps
  always_comb begin
    x_ext = {1'b0, DrawX};
    y_ext = {1'b0, DrawY};
    x_lo  = {1'b0, x_s};
    y_lo  = {1'b0, y_s};
    x_hi  = x_lo + 11'(SPRITE_W);
    y_hi  = y_lo + 11'(SPRITE_H);
    inbox = en_s && (x_ext >= x_lo) && (x_ext < x_hi) && (y_ext >= y_lo) && (y_ext < y_hi);
  end

  assign col_raw = DrawX[CW-1:0] - x_s[CW-1:0];
  assign row     = DrawY[RW-1:0] - y_s[RW-1:0];

`ifdef DUCK_MIRROR_EN
  logic mir_s;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mir_s <= 1'b0;
    end else if (frame_start) begin
      mir_s <= mirror;
    end
  end

  // SPRITE_W is a power of two, so W-1-col is the bitwise inverse
  assign col = mir_s ? ~col_raw : col_raw;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign col = col_raw;
`endif

  // Frame-start bookkeeping: shadows and animation divider
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vsync_d <= 1'b0;
      x_s     <= '0;
      y_s     <= '0;
      en_s    <= 1'b0;
      div_cnt <= '0;
      frame   <= '0;
    end else begin
      vsync_d <= vsync;
      if (frame_start) begin
        x_s  <= duck_x;
        y_s  <= duck_y;
        en_s <= duck_en;
        if (en_s) begin
          if (div_cnt == DW'(FRAME_DIV - 1)) begin
            div_cnt <= '0;
            frame   <= frame + FW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
      end
    end
  end

  // Pixel pipeline: address, ROM access, palette output
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      inbox_d1  <= 1'b0;
      inbox_d2  <= 1'b0;
      pal_index <= '0;
      pixel_on  <= 1'b0;
    end else begin
      rom_addr  <= inbox ? ADDR_W'({frame, row, col}) : '0;
      inbox_d1  <= inbox;
      inbox_d2  <= inbox_d1;
      pal_index <= inbox_d2 ? rom_q : TRANSPARENT_IDX;
      pixel_on  <= inbox_d2 && (rom_q != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed + randomized bench for duck_sprite_fetch against a pixel-level reference model.
module tb_duck_sprite_fetch;

  localparam int W   = 64;
  localparam int H   = 64;
  localparam int NF  = 4;
  localparam int DIV = 8;
  localparam logic [3:0] TIDX = 4'h0;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY, duck_x, duck_y;
  logic        vsync, duck_en, mirror;
  logic [13:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pal_index;
  logic        pixel_on;
  logic [1:0]  frame;

  logic [3:0]  rom_mem [W*H*NF];

  int tests = 0;
  int fails = 0;

  // Reference state: sprite shadows and animation position
  int m_sx, m_sy, m_cnt, m_frame;
  bit m_en, m_mir;

  duck_sprite_fetch dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .vsync     (vsync),
    .duck_x    (duck_x),
    .duck_y    (duck_y),
    .duck_en   (duck_en),
    .mirror    (mirror),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pal_index (pal_index),
    .pixel_on  (pixel_on),
    .frame     (frame)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_q <= rom_mem[rom_addr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_en = 0; m_mir = 0; m_cnt = 0; m_frame = 0;
  endtask

  // One vsync low pulse; the model takes its frame-start effect at the falling edge
  task automatic pulse();
    vsync = 1'b0;
    step();
    if (m_en) begin
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt   = 0;
        m_frame = (m_frame + 1) % NF;
      end
    end
    m_sx = duck_x;
    m_sy = duck_y;
    m_en = duck_en;
`ifdef DUCK_MIRROR_EN
    m_mir = mirror;
`else
    m_mir = 0;
`endif
    vsync = 1'b1;
    step();
  endtask

  task automatic present(input string tag, input int x, input int y);
    bit         ib;
    int         col, eaddr;
    logic [3:0] data;
    DrawX = 10'(x);
    DrawY = 10'(y);
    ib    = m_en && x >= m_sx && x < m_sx + W && y >= m_sy && y < m_sy + H;
    col   = m_mir ? (W - 1 - (x - m_sx)) : (x - m_sx);
    eaddr = ib ? (m_frame * W * H + (y - m_sy) * W + col) : 0;
    step();
    chk({tag, ".addr"}, 32'(rom_addr), 32'(eaddr));
    step();
    step();
    data = rom_mem[eaddr];
    chk({tag, ".pal"}, 32'(pal_index), ib ? 32'(data) : 32'(TIDX));
    chk({tag, ".on"}, 32'(pixel_on), 32'(ib && data != TIDX));
  endtask

  initial begin
    for (int i = 0; i < W * H * NF; i++) rom_mem[i] = 4'($urandom_range(0, 15));

    // Reset with random inputs
    Reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      DrawX   = 10'($urandom_range(0, 799));
      DrawY   = 10'($urandom_range(0, 524));
      vsync   = 1'($urandom);
      duck_x  = 10'($urandom_range(0, 639));
      duck_y  = 10'($urandom_range(0, 479));
      duck_en = 1'($urandom);
      mirror  = 1'($urandom);
      step();
    end
    Reset_n = 1'b1;
    vsync   = 1'b1;
    model_reset();
    step();
    chk("rst.pixel_on", 32'(pixel_on), 32'd0);
    chk("rst.pal_index", 32'(pal_index), 32'd0);
    chk("rst.frame", 32'(frame), 32'd0);
    chk("rst.rom_addr", 32'(rom_addr), 32'd0);
    present("rst.noshadow", m_sx + 1, m_sy + 1);

    // Basic fetch
    duck_x = 10'd100; duck_y = 10'd50; duck_en = 1'b1; mirror = 1'b0;
    pulse();
    rom_mem[14'h0083] = 4'd3;
    present("basic", 103, 52);
    chk("basic.const_addr_model", 32'(m_frame * W * H + 2 * W + 3), 32'h83);

    // Transparency, left-edge miss
    rom_mem[14'h0083] = TIDX;
    present("transp", 103, 52);
    present("left_miss", 99, 52);
    present("top_left", 100, 50);

    // Right-edge clipping
    duck_x = 10'd600; duck_y = 10'd400;
    pulse();
    present("clip639", 639, 410);
    present("clip664", 664, 410);
    present("clip663", 663, 463);
    present("bottom_miss", 620, 464);

    // Randomized positions, mirror and shadow updates
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        duck_x  = 10'($urandom_range(0, 700));
        duck_y  = 10'($urandom_range(0, 480));
        duck_en = ($urandom_range(0, 4) != 0);
        mirror  = 1'($urandom);
        pulse();
      end else begin
        duck_x = 10'($urandom_range(0, 700));  // mid-frame change must not matter
      end
      present("rand", $urandom_range(m_sx > 8 ? m_sx - 8 : 0, m_sx + W + 8 > 799 ? 799 : m_sx + W + 8),
              $urandom_range(m_sy > 8 ? m_sy - 8 : 0, m_sy + H + 8 > 524 ? 524 : m_sy + H + 8));
    end

    // Animation sequencing
    duck_en = 1'b1; mirror = 1'b0; duck_x = 10'd200; duck_y = 10'd100;
    for (int i = 0; i < 33; i++) begin
      pulse();
      chk("anim.frame", 32'(frame), 32'(m_frame));
    end
    present("anim.addr", 230, 120);
    duck_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pulse();
      chk("anim.hold", 32'(frame), 32'(m_frame));
    end
    present("disabled", 230, 120);

    // Mirror
    duck_en = 1'b1; mirror = 1'b1; duck_x = 10'd100; duck_y = 10'd50;
    pulse();
    present("mirror", 100, 50);
`ifdef DUCK_MIRROR_EN
    chk("mirror.col", 32'(rom_addr[5:0]), 32'd63);
`else
    chk("mirror.col", 32'(rom_addr[5:0]), 32'd0);
`endif

    // Tear-free: shadow only moves at the next frame start
    mirror = 1'b0;
    pulse();
    duck_x = 10'd300;
    present("tear.old", 110, 60);
    present("tear.new_box", 310, 60);
    pulse();
    present("tear.after", 310, 60);
    present("tear.old_box", 110, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
